// File: rtl/hdmi_scan_ctrl.sv
// Raster scan timing generator for the HDMI path, with one-line-ahead
// framebuffer fetch scheduling and a sticky deadline-miss flag.
module hdmi_scan_ctrl #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FP       = 110,
  parameter int unsigned H_SYNC     = 40,
  parameter int unsigned H_BP       = 220,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned V_FP       = 5,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 20,
  parameter bit          HSYNC_POL  = 1'b1,
  parameter bit          VSYNC_POL  = 1'b1,
  parameter int unsigned FETCH_LEAD = 64
) (
  input  logic        clk_pixel,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        frame_start,
  output logic        line_req,
  output logic [10:0] line_req_y,
  input  logic        line_ack,
  output logic        underrun
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] REQ_H    = 12'(H_TOTAL - FETCH_LEAD);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

  fetch_state_t state, state_next;

  logic [11:0] h_next;
  logic [10:0] v_next;
  logic [10:0] n_next;
  logic        req_next;
  logic        load_y;
  logic        set_underrun;

  // All outputs are registered from the upcoming position, so x/y and the
  // decoded strobes describe the same (h,v) in the same cycle.
  always_comb begin
    h_next = x + 12'd1;
    v_next = y;
    if (x == H_LAST) begin
      h_next = '0;
      v_next = (y == V_LAST) ? '0 : y + 11'd1;
    end
    n_next   = (v_next == V_LAST) ? '0 : v_next + 11'd1;
    req_next = (h_next == REQ_H) && (n_next < V_ACT_W);
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      x           <= '0;
      y           <= V_ACT_W;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= h_next;
      y           <= v_next;
      hsync       <= (h_next >= HS_START && h_next < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= (v_next >= VS_START && v_next < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      active      <= (h_next < H_ACT_W) && (v_next < V_ACT_W);
      frame_start <= (h_next == '0) && (v_next == '0);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A new request point while still pending always wins; the old line is
  // dropped, and counted as an underrun only if it was not acked this cycle.
  always_comb begin
    state_next   = state;
    load_y       = 1'b0;
    set_underrun = 1'b0;
    case (state)
      IDLE: begin
        if (req_next) begin
          state_next = REQ;
          load_y     = 1'b1;
        end
      end
      REQ: begin
        if (req_next) begin
          load_y       = 1'b1;
          set_underrun = ~line_ack;
        end else if (line_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    line_req = (state == REQ);
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      line_req_y <= '0;
      underrun   <= 1'b0;
    end else begin
      if (load_y)       line_req_y <= n_next;
      if (set_underrun) underrun   <= 1'b1;
    end
  end

endmodule
